// File: rtl/ddr2_wr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ddr2_wr_arbiter_pkg
//   Shared definitions for the DDR2 two-client write arbiter:
//   bus widths of the DDR2 address/write-data FIFOs, the default burst
//   length in wdf beats, and the arbiter FSM state encoding.
// ---------------------------------------------------------------------------
package ddr2_wr_arbiter_pkg;

   localparam int DDR2_ADDR_W = 31;   // af word width
   localparam int DDR2_DATA_W = 128;  // wdf data width
   localparam int DDR2_MASK_W = 16;   // wdf byte-mask width
   localparam int DDR2_BEATS  = 2;    // wdf words per burst

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_BURST = 1'b1
   } arb_state_e;

endpackage

// File: rtl/ddr2_wr_mux.sv
// ---------------------------------------------------------------------------
// ddr2_wr_mux
//   Purely combinational owner select for the DDR2 write path.
//   Ports:
//     sel_i              owning client (0/1); ignored when vld_i is low
//     vld_i              a burst is in progress (an owner exists)
//     cN_*_i             per-client address, data, mask and write requests
//     af_addr_o/wdf_o/wdf_mask_o  muxed address/data/mask (client 0 when idle)
//     af_req_o/wdf_req_o owner's af/wdf write request, 0 when no owner
// ---------------------------------------------------------------------------
module ddr2_wr_mux
   import ddr2_wr_arbiter_pkg::*;
(
   input  logic                   sel_i,
   input  logic                   vld_i,
   input  logic [DDR2_ADDR_W-1:0] c0_af_addr_i,
   input  logic                   c0_af_wr_en_i,
   input  logic [DDR2_DATA_W-1:0] c0_wdf_i,
   input  logic [DDR2_MASK_W-1:0] c0_wdf_mask_i,
   input  logic                   c0_wdf_wr_en_i,
   input  logic [DDR2_ADDR_W-1:0] c1_af_addr_i,
   input  logic                   c1_af_wr_en_i,
   input  logic [DDR2_DATA_W-1:0] c1_wdf_i,
   input  logic [DDR2_MASK_W-1:0] c1_wdf_mask_i,
   input  logic                   c1_wdf_wr_en_i,
   output logic [DDR2_ADDR_W-1:0] af_addr_o,
   output logic [DDR2_DATA_W-1:0] wdf_o,
   output logic [DDR2_MASK_W-1:0] wdf_mask_o,
   output logic                   af_req_o,
   output logic                   wdf_req_o
);

   // Without an owner the data path parks on client 0.
   logic use_c1;
   assign use_c1 = vld_i & sel_i;

   assign af_addr_o  = use_c1 ? c1_af_addr_i  : c0_af_addr_i;
   assign wdf_o      = use_c1 ? c1_wdf_i      : c0_wdf_i;
   assign wdf_mask_o = use_c1 ? c1_wdf_mask_i : c0_wdf_mask_i;
   assign af_req_o   = vld_i & (use_c1 ? c1_af_wr_en_i  : c0_af_wr_en_i);
   assign wdf_req_o  = vld_i & (use_c1 ? c1_wdf_wr_en_i : c0_wdf_wr_en_i);

endmodule

// File: rtl/ddr2_wr_arbiter.sv
// ---------------------------------------------------------------------------
// ddr2_wr_arbiter
//   Round-robin two-client burst arbiter in front of the DDR2 af/wdf FIFOs.
//   A granted client pushes one af word and BEATS wdf words; bursts are
//   never interleaved. One idle cycle separates consecutive bursts.
//   Ports:
//     clk, rst                         clock, synchronous active-high reset
//     cN_af_addr_din/cN_af_wr_en       client N address request
//     cN_wdf_din/cN_wdf_mask_din/cN_wdf_wr_en  client N write data request
//     cN_af_full/cN_wdf_full           back-pressure to client N
//     af_full/wdf_full                 DDR2 FIFO full flags
//     af_addr_din/af_wr_en             DDR2 af push
//     wdf_din/wdf_mask_din/wdf_wr_en   DDR2 wdf push
//     grant                            one-hot current owner, 00 = none
// ---------------------------------------------------------------------------
module ddr2_wr_arbiter
   import ddr2_wr_arbiter_pkg::*;
#(
   parameter int BEATS = DDR2_BEATS,
   parameter int CNT_W = 2
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic [DDR2_ADDR_W-1:0] c0_af_addr_din,
   input  logic                   c0_af_wr_en,
   input  logic [DDR2_DATA_W-1:0] c0_wdf_din,
   input  logic [DDR2_MASK_W-1:0] c0_wdf_mask_din,
   input  logic                   c0_wdf_wr_en,
   output logic                   c0_af_full,
   output logic                   c0_wdf_full,
   input  logic [DDR2_ADDR_W-1:0] c1_af_addr_din,
   input  logic                   c1_af_wr_en,
   input  logic [DDR2_DATA_W-1:0] c1_wdf_din,
   input  logic [DDR2_MASK_W-1:0] c1_wdf_mask_din,
   input  logic                   c1_wdf_wr_en,
   output logic                   c1_af_full,
   output logic                   c1_wdf_full,
   input  logic                   af_full,
   input  logic                   wdf_full,
   output logic [DDR2_ADDR_W-1:0] af_addr_din,
   output logic                   af_wr_en,
   output logic [DDR2_DATA_W-1:0] wdf_din,
   output logic [DDR2_MASK_W-1:0] wdf_mask_din,
   output logic                   wdf_wr_en,
   output logic [1:0]             grant
);

   localparam logic [CNT_W-1:0] BEATS_C = CNT_W'(BEATS);

   arb_state_e       state_q, state_d;
   logic             owner_q, owner_d;
   logic             af_done_q, af_done_d;
   logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
   logic             rr_last_q, rr_last_d;

   logic             in_burst;
   logic             req0, req1;
   logic             own_af_req, own_wdf_req;
   logic             af_acc, wdf_acc;
   logic [CNT_W-1:0] beat_next;
   logic             burst_end;
   logic             own0, own1;

   assign in_burst = (state_q == ARB_BURST);
   assign req0     = c0_af_wr_en | c0_wdf_wr_en;
   assign req1     = c1_af_wr_en | c1_wdf_wr_en;

   ddr2_wr_mux u_mux (
      .sel_i          (owner_q),
      .vld_i          (in_burst),
      .c0_af_addr_i   (c0_af_addr_din),
      .c0_af_wr_en_i  (c0_af_wr_en),
      .c0_wdf_i       (c0_wdf_din),
      .c0_wdf_mask_i  (c0_wdf_mask_din),
      .c0_wdf_wr_en_i (c0_wdf_wr_en),
      .c1_af_addr_i   (c1_af_addr_din),
      .c1_af_wr_en_i  (c1_af_wr_en),
      .c1_wdf_i       (c1_wdf_din),
      .c1_wdf_mask_i  (c1_wdf_mask_din),
      .c1_wdf_wr_en_i (c1_wdf_wr_en),
      .af_addr_o      (af_addr_din),
      .wdf_o          (wdf_din),
      .wdf_mask_o     (wdf_mask_din),
      .af_req_o       (own_af_req),
      .wdf_req_o      (own_wdf_req)
   );

   // Accepts: af once per burst, wdf until BEATS words are taken.
   assign af_acc    = own_af_req  & ~af_done_q & ~af_full;
   assign wdf_acc   = own_wdf_req & (beat_cnt_q < BEATS_C) & ~wdf_full;
   assign beat_next = beat_cnt_q + CNT_W'(wdf_acc);
   assign burst_end = in_burst & (af_done_q | af_acc) & (beat_next == BEATS_C);

   assign af_wr_en  = af_acc;
   assign wdf_wr_en = wdf_acc;

   assign own0  = in_burst & ~owner_q;
   assign own1  = in_burst &  owner_q;
   assign grant = {own1, own0};

   assign c0_af_full  = ~own0 | af_done_q | af_full;
   assign c1_af_full  = ~own1 | af_done_q | af_full;
   assign c0_wdf_full = ~own0 | (beat_cnt_q == BEATS_C) | wdf_full;
   assign c1_wdf_full = ~own1 | (beat_cnt_q == BEATS_C) | wdf_full;

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      af_done_d  = af_done_q;
      beat_cnt_d = beat_cnt_q;
      rr_last_d  = rr_last_q;
      if (state_q == ARB_IDLE) begin
         if (req0 | req1) begin
            state_d = ARB_BURST;
            // On a tie the client not served last wins.
            owner_d = (req0 & req1) ? ~rr_last_q : req1;
         end
      end else begin
         if (burst_end) begin
            state_d    = ARB_IDLE;
            rr_last_d  = owner_q;
            af_done_d  = 1'b0;
            beat_cnt_d = '0;
         end else begin
            af_done_d  = af_done_q | af_acc;
            beat_cnt_d = beat_next;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ARB_IDLE;
         owner_q    <= 1'b0;
         af_done_q  <= 1'b0;
         beat_cnt_q <= '0;
         rr_last_q  <= 1'b1;   // client 0 wins the first tie
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         af_done_q  <= af_done_d;
         beat_cnt_q <= beat_cnt_d;
         rr_last_q  <= rr_last_d;
      end
   end

endmodule

// File: tb/tb_ddr2_wr_arbiter.sv
module tb_ddr2_wr_arbiter;
   import ddr2_wr_arbiter_pkg::*;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic [DDR2_ADDR_W-1:0] c0_af_addr_din = '0, c1_af_addr_din = '0;
   logic                   c0_af_wr_en = 1'b0, c1_af_wr_en = 1'b0;
   logic [DDR2_DATA_W-1:0] c0_wdf_din = '0, c1_wdf_din = '0;
   logic [DDR2_MASK_W-1:0] c0_wdf_mask_din = '0, c1_wdf_mask_din = '0;
   logic                   c0_wdf_wr_en = 1'b0, c1_wdf_wr_en = 1'b0;
   logic                   c0_af_full, c0_wdf_full, c1_af_full, c1_wdf_full;
   logic                   af_full = 1'b0, wdf_full = 1'b0;
   logic [DDR2_ADDR_W-1:0] af_addr_din;
   logic                   af_wr_en;
   logic [DDR2_DATA_W-1:0] wdf_din;
   logic [DDR2_MASK_W-1:0] wdf_mask_din;
   logic                   wdf_wr_en;
   logic [1:0]             grant;

   int n_checks = 0;
   int n_errors = 0;

   ddr2_wr_arbiter dut (
      .clk(clk), .rst(rst),
      .c0_af_addr_din(c0_af_addr_din), .c0_af_wr_en(c0_af_wr_en),
      .c0_wdf_din(c0_wdf_din), .c0_wdf_mask_din(c0_wdf_mask_din),
      .c0_wdf_wr_en(c0_wdf_wr_en), .c0_af_full(c0_af_full), .c0_wdf_full(c0_wdf_full),
      .c1_af_addr_din(c1_af_addr_din), .c1_af_wr_en(c1_af_wr_en),
      .c1_wdf_din(c1_wdf_din), .c1_wdf_mask_din(c1_wdf_mask_din),
      .c1_wdf_wr_en(c1_wdf_wr_en), .c1_af_full(c1_af_full), .c1_wdf_full(c1_wdf_full),
      .af_full(af_full), .wdf_full(wdf_full),
      .af_addr_din(af_addr_din), .af_wr_en(af_wr_en),
      .wdf_din(wdf_din), .wdf_mask_din(wdf_mask_din), .wdf_wr_en(wdf_wr_en),
      .grant(grant)
   );

   always #5 clk = ~clk;

   // Each tag maps to a distinct address / data / mask pattern.
   function automatic logic [DDR2_ADDR_W-1:0] mk_addr(input logic [7:0] t);
      return {t, ~t, 15'h02a5};
   endfunction
   function automatic logic [DDR2_DATA_W-1:0] mk_data(input logic [7:0] t);
      return {8{t, ~t}};
   endfunction
   function automatic logic [DDR2_MASK_W-1:0] mk_mask(input logic [7:0] t);
      return {~t, t};
   endfunction

   typedef struct {
      logic       rst;
      logic [1:0] q0;      // {af_wr_en, wdf_wr_en} of client 0
      logic [7:0] t0;
      logic [1:0] q1;
      logic [7:0] t1;
      logic       af_f;
      logic       wdf_f;
      logic [1:0] g;       // expected grant
      logic       ea;      // expected af_wr_en
      logic       ew;      // expected wdf_wr_en
      logic [3:0] ef;      // expected {c0_af_full, c0_wdf_full, c1_af_full, c1_wdf_full}
   } vec_t;

   function automatic vec_t v(input logic r, input logic [1:0] q0, input logic [7:0] t0,
                              input logic [1:0] q1, input logic [7:0] t1,
                              input logic af_f, input logic wdf_f, input logic [1:0] g,
                              input logic ea, input logic ew, input logic [3:0] ef);
      vec_t x;
      x.rst = r; x.q0 = q0; x.t0 = t0; x.q1 = q1; x.t1 = t1;
      x.af_f = af_f; x.wdf_f = wdf_f; x.g = g; x.ea = ea; x.ew = ew; x.ef = ef;
      return x;
   endfunction

   // Scoreboard: expected tags of pushes, in order.
   logic [7:0] exp_af_q[$];
   logic [7:0] exp_wdf_q[$];

   task automatic drive(input logic r, input logic [1:0] q0, input logic [7:0] t0,
                        input logic [1:0] q1, input logic [7:0] t1,
                        input logic af_f, input logic wdf_f);
      rst = r;
      c0_af_wr_en = q0[1]; c0_wdf_wr_en = q0[0];
      c0_af_addr_din = mk_addr(t0); c0_wdf_din = mk_data(t0); c0_wdf_mask_din = mk_mask(t0);
      c1_af_wr_en = q1[1]; c1_wdf_wr_en = q1[0];
      c1_af_addr_din = mk_addr(t1); c1_wdf_din = mk_data(t1); c1_wdf_mask_din = mk_mask(t1);
      af_full = af_f; wdf_full = wdf_f;
   endtask

   task automatic expect_push(input logic [1:0] g, input logic ea, input logic ew,
                              input logic [7:0] t0, input logic [7:0] t1);
      logic [7:0] t;
      t = g[1] ? t1 : t0;
      if (ea) exp_af_q.push_back(t);
      if (ew) exp_wdf_q.push_back(t);
   endtask

   task automatic check_ctl(input string name, input logic [1:0] g, input logic ea,
                            input logic ew, input logic [3:0] ef);
      logic [8:0] act, req;
      act = {grant, af_wr_en, wdf_wr_en, c0_af_full, c0_wdf_full, c1_af_full, c1_wdf_full};
      req = {g, ea, ew, ef};
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: {grant,af_en,wdf_en,fulls} actual=%b required=%b", name, act, req);
      end
   endtask

   // Monitor: every DUT push is compared against the scoreboard head.
   always @(negedge clk) begin
      if (af_wr_en === 1'b1) begin
         n_checks++;
         if (exp_af_q.size() == 0) begin
            n_errors++;
            $display("FAIL af_push: actual addr=%h required=no push", af_addr_din);
         end else begin
            logic [7:0] t;
            t = exp_af_q.pop_front();
            if (af_addr_din !== mk_addr(t)) begin
               n_errors++;
               $display("FAIL af_addr: actual=%h required=%h", af_addr_din, mk_addr(t));
            end else
               $display("af push  addr=%h tag=%h", af_addr_din, t);
         end
      end
      if (wdf_wr_en === 1'b1) begin
         n_checks++;
         if (exp_wdf_q.size() == 0) begin
            n_errors++;
            $display("FAIL wdf_push: actual data=%h required=no push", wdf_din);
         end else begin
            logic [7:0] t;
            t = exp_wdf_q.pop_front();
            if (wdf_din !== mk_data(t) || wdf_mask_din !== mk_mask(t)) begin
               n_errors++;
               $display("FAIL wdf_data: actual=%h/%h required=%h/%h",
                        wdf_din, wdf_mask_din, mk_data(t), mk_mask(t));
            end else
               $display("wdf push data=%h mask=%h tag=%h", wdf_din, wdf_mask_din, t);
         end
      end
   end

   vec_t tbl[$];

   initial begin
      // reset state
      tbl.push_back(v(1, 2'b00, 8'h00, 2'b00, 8'h00, 0, 0, 2'b00, 0, 0, 4'b1111));
      // 1: c0 alone, af+beat0 then beat1
      tbl.push_back(v(0, 2'b11, 8'h10, 2'b00, 8'h00, 0, 0, 2'b00, 0, 0, 4'b1111));
      tbl.push_back(v(0, 2'b11, 8'h10, 2'b00, 8'h00, 0, 0, 2'b01, 1, 1, 4'b0011));
      tbl.push_back(v(0, 2'b01, 8'h11, 2'b00, 8'h00, 0, 0, 2'b01, 0, 1, 4'b1011));
      tbl.push_back(v(0, 2'b00, 8'h00, 2'b00, 8'h00, 0, 0, 2'b00, 0, 0, 4'b1111));
      // 2: tie after reset, c0 first then c1 after the gap
      tbl.push_back(v(1, 2'b00, 8'h00, 2'b00, 8'h00, 0, 0, 2'b00, 0, 0, 4'b1111));
      tbl.push_back(v(0, 2'b11, 8'h20, 2'b11, 8'h30, 0, 0, 2'b00, 0, 0, 4'b1111));
      tbl.push_back(v(0, 2'b11, 8'h20, 2'b11, 8'h30, 0, 0, 2'b01, 1, 1, 4'b0011));
      tbl.push_back(v(0, 2'b01, 8'h21, 2'b11, 8'h30, 0, 0, 2'b01, 0, 1, 4'b1011));
      tbl.push_back(v(0, 2'b00, 8'h00, 2'b11, 8'h30, 0, 0, 2'b00, 0, 0, 4'b1111));
      tbl.push_back(v(0, 2'b00, 8'h00, 2'b11, 8'h30, 0, 0, 2'b10, 1, 1, 4'b1100));
      tbl.push_back(v(0, 2'b00, 8'h00, 2'b01, 8'h31, 0, 0, 2'b10, 0, 1, 4'b1110));
      tbl.push_back(v(0, 2'b00, 8'h00, 2'b00, 8'h00, 0, 0, 2'b00, 0, 0, 4'b1111));
      // 3: wdf_full for 5 cycles stalls beat1
      tbl.push_back(v(0, 2'b11, 8'h40, 2'b00, 8'h00, 0, 0, 2'b00, 0, 0, 4'b1111));
      tbl.push_back(v(0, 2'b11, 8'h40, 2'b00, 8'h00, 0, 0, 2'b01, 1, 1, 4'b0011));
      for (int i = 0; i < 5; i++)
         tbl.push_back(v(0, 2'b01, 8'h41, 2'b00, 8'h00, 0, 1, 2'b01, 0, 0, 4'b1111));
      tbl.push_back(v(0, 2'b01, 8'h41, 2'b00, 8'h00, 0, 0, 2'b01, 0, 1, 4'b1011));
      tbl.push_back(v(0, 2'b00, 8'h00, 2'b00, 8'h00, 0, 0, 2'b00, 0, 0, 4'b1111));
      // 4: c1 beats before af, third beat blocked until the next grant
      tbl.push_back(v(0, 2'b00, 8'h00, 2'b01, 8'h50, 0, 0, 2'b00, 0, 0, 4'b1111));
      tbl.push_back(v(0, 2'b00, 8'h00, 2'b01, 8'h50, 0, 0, 2'b10, 0, 1, 4'b1100));
      tbl.push_back(v(0, 2'b00, 8'h00, 2'b01, 8'h51, 0, 0, 2'b10, 0, 1, 4'b1100));
      tbl.push_back(v(0, 2'b00, 8'h00, 2'b11, 8'h52, 0, 0, 2'b10, 1, 0, 4'b1101));
      tbl.push_back(v(0, 2'b00, 8'h00, 2'b01, 8'h52, 0, 0, 2'b00, 0, 0, 4'b1111));
      tbl.push_back(v(0, 2'b00, 8'h00, 2'b01, 8'h52, 0, 0, 2'b10, 0, 1, 4'b1100));
      tbl.push_back(v(0, 2'b00, 8'h00, 2'b10, 8'h53, 0, 0, 2'b10, 1, 0, 4'b1100));
      // 6: rst the cycle after the c1 af accept, then c0 wins the first tie
      tbl.push_back(v(1, 2'b00, 8'h00, 2'b00, 8'h54, 0, 0, 2'b10, 0, 0, 4'b1110));
      tbl.push_back(v(0, 2'b11, 8'h60, 2'b11, 8'h70, 0, 0, 2'b00, 0, 0, 4'b1111));
      tbl.push_back(v(0, 2'b11, 8'h60, 2'b11, 8'h70, 0, 0, 2'b01, 1, 1, 4'b0011));
      tbl.push_back(v(0, 2'b01, 8'h61, 2'b11, 8'h70, 0, 0, 2'b01, 0, 1, 4'b1011));
      tbl.push_back(v(0, 2'b00, 8'h00, 2'b11, 8'h70, 0, 0, 2'b00, 0, 0, 4'b1111));
      tbl.push_back(v(0, 2'b00, 8'h00, 2'b11, 8'h70, 0, 0, 2'b10, 1, 1, 4'b1100));
      tbl.push_back(v(0, 2'b00, 8'h00, 2'b01, 8'h71, 0, 0, 2'b10, 0, 1, 4'b1110));
      tbl.push_back(v(0, 2'b00, 8'h00, 2'b00, 8'h00, 0, 0, 2'b00, 0, 0, 4'b1111));

      repeat (2) @(posedge clk);
      foreach (tbl[i]) begin
         @(posedge clk); #1;
         drive(tbl[i].rst, tbl[i].q0, tbl[i].t0, tbl[i].q1, tbl[i].t1,
               tbl[i].af_f, tbl[i].wdf_f);
         expect_push(tbl[i].g, tbl[i].ea, tbl[i].ew, tbl[i].t0, tbl[i].t1);
         @(negedge clk);
         check_ctl($sformatf("row%0d", i), tbl[i].g, tbl[i].ea, tbl[i].ew, tbl[i].ef);
      end

      // 5: both clients requesting continuously for 8 bursts
      @(posedge clk); #1;
      drive(1, 2'b00, 8'h00, 2'b00, 8'h00, 0, 0);
      @(negedge clk);
      check_ctl("rr_rst", 2'b00, 0, 0, 4'b1111);
      for (int k = 0; k < 8; k++) begin
         logic [1:0] g;
         logic [3:0] f1, f2;
         g  = (k % 2 == 0) ? 2'b01 : 2'b10;
         f1 = (k % 2 == 0) ? 4'b0011 : 4'b1100;
         f2 = (k % 2 == 0) ? 4'b1011 : 4'b1110;
         @(posedge clk); #1;
         drive(0, 2'b11, 8'h80, 2'b11, 8'h90, 0, 0);
         @(negedge clk);
         check_ctl($sformatf("rr%0d_gap", k), 2'b00, 0, 0, 4'b1111);
         @(posedge clk); #1;
         expect_push(g, 1, 1, 8'h80, 8'h90);
         @(negedge clk);
         check_ctl($sformatf("rr%0d_b0", k), g, 1, 1, f1);
         @(posedge clk); #1;
         expect_push(g, 0, 1, 8'h80, 8'h90);
         @(negedge clk);
         check_ctl($sformatf("rr%0d_b1", k), g, 0, 1, f2);
      end
      @(posedge clk); #1;
      drive(0, 2'b00, 8'h00, 2'b00, 8'h00, 0, 0);
      repeat (3) @(negedge clk);

      n_checks++;
      if (exp_af_q.size() != 0 || exp_wdf_q.size() != 0) begin
         n_errors++;
         $display("FAIL drain: pending af=%0d wdf=%0d required 0 0",
                  exp_af_q.size(), exp_wdf_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
